clock_set_ctrl: RTL and testbench

//  Pushbutton input side of the Basys3 clock: debounces the five board buttons and runs a RUN/EDIT FSM.
//  In EDIT, the user selects a digit and edits MM:SS, with one digit selected at a time.

---
 rtl/clock_set_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// Button front end for the MM:SS clock: debounces five buttons and runs the RUN/EDIT set FSM.
// Optional macro AUTO_REPEAT_EN: held up/down buttons re-fire every REPEAT_CYCLES.
module clock_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int BLINK_CYCLES    = 25000000,
    parameter int REPEAT_CYCLES   = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_c,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic       btn_u,
    input  logic       btn_d,
    input  logic [3:0] cur_sec_ones,
    input  logic [2:0] cur_sec_tens,
    input  logic [3:0] cur_min_ones,
    input  logic [2:0] cur_min_tens,
    output logic       timer_en,
    output logic       load,
    output logic [3:0] set_sec_ones,
    output logic [2:0] set_sec_tens,
    output logic [3:0] set_min_ones,
    output logic [2:0] set_min_tens,
    output logic [1:0] digit_sel,
    output logic [3:0] blink_mask
);

    // state | meaning
    // RUN   | timer counting, buttons other than c ignored
    // EDIT  | timer stopped, selected digit blinks and is editable
    typedef enum logic {RUN, EDIT} state_t;

    localparam int BC = 0, BL = 1, BR = 2, BU = 3, BD = 4;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BW = $clog2(BLINK_CYCLES + 1);
    localparam logic [DW-1:0] DB_LOAD = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] BL_LOAD = BW'(BLINK_CYCLES - 1);

    logic [4:0]    raw, sync1, sync2, db, db_q, press, rep_tick;
    logic [DW-1:0] db_cnt [5];
    state_t        state, state_nx;
    logic          go_edit, go_run, mv_l, mv_r, inc, dec;
    logic [BW-1:0] blink_cnt;
    logic          blink_ph;

    assign raw = {btn_d, btn_u, btn_r, btn_l, btn_c};

    // Down-counter reloads whenever the synchronised level agrees with the accepted one
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_q  <= '0;
            press <= '0;
            for (int i = 0; i < 5; i++) db_cnt[i] <= DB_LOAD;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            db_q  <= db;
            press <= (db & ~db_q) | rep_tick;
            for (int i = 0; i < 5; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= DB_LOAD;
                end else if (db_cnt[i] == '0) begin
                    db[i]     <= sync2[i];
                    db_cnt[i] <= DB_LOAD;
                end else begin
                    db_cnt[i] <= db_cnt[i] - DW'(1);
                end
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] RP_LOAD = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rep_cnt [2];

    always_ff @(posedge clk) begin
        for (int j = 0; j < 2; j++) begin
            if (reset || !db[BU+j] || !db_q[BU+j] || rep_cnt[j] == '0)
                rep_cnt[j] <= RP_LOAD;
            else
                rep_cnt[j] <= rep_cnt[j] - RW'(1);
        end
    end

    always_comb begin
        rep_tick     = '0;
        rep_tick[BU] = db[BU] & db_q[BU] & (rep_cnt[0] == '0);
        rep_tick[BD] = db[BD] & db_q[BD] & (rep_cnt[1] == '0);
    end
`else
    assign rep_tick = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            RUN:     if (press[BC]) state_nx = EDIT;
            EDIT:    if (press[BC]) state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    always_comb begin
        timer_en   = (state == RUN);
        blink_mask = '0;
        if (state == EDIT && blink_ph) blink_mask = 4'b0001 << digit_sel;
    end

    // c beats everything; l/r beats u/d; opposing pairs cancel
    assign go_edit = (state == RUN)  & press[BC];
    assign go_run  = (state == EDIT) & press[BC];
    assign mv_l    = (state == EDIT) & ~press[BC] & press[BL] & ~press[BR];
    assign mv_r    = (state == EDIT) & ~press[BC] & press[BR] & ~press[BL];
    assign inc     = (state == EDIT) & ~press[BC] & ~press[BL] & ~press[BR] & press[BU] & ~press[BD];
    assign dec     = (state == EDIT) & ~press[BC] & ~press[BL] & ~press[BR] & press[BD] & ~press[BU];

    function automatic logic [3:0] step_ones(input logic [3:0] v, input logic up);
        if (up) return (v >= 4'd9) ? 4'd0 : v + 4'd1;
        else    return (v == 4'd0) ? 4'd9 : v - 4'd1;
    endfunction

    function automatic logic [2:0] step_tens(input logic [2:0] v, input logic up);
        if (up) return (v >= 3'd5) ? 3'd0 : v + 3'd1;
        else    return (v == 3'd0) ? 3'd5 : v - 3'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            load         <= 1'b0;
            set_sec_ones <= '0;
            set_sec_tens <= '0;
            set_min_ones <= '0;
            set_min_tens <= '0;
            digit_sel    <= '0;
        end else begin
            load <= go_run;
            if (go_edit) begin
                set_sec_ones <= (cur_sec_ones > 4'd9) ? 4'd9 : cur_sec_ones;
                set_sec_tens <= (cur_sec_tens > 3'd5) ? 3'd5 : cur_sec_tens;
                set_min_ones <= (cur_min_ones > 4'd9) ? 4'd9 : cur_min_ones;
                set_min_tens <= (cur_min_tens > 3'd5) ? 3'd5 : cur_min_tens;
                digit_sel    <= 2'd0;
            end else begin
                if (mv_l) digit_sel <= digit_sel + 2'd1;
                if (mv_r) digit_sel <= digit_sel - 2'd1;
                if (inc || dec) begin
                    case (digit_sel)
                        2'd0: set_sec_ones <= step_ones(set_sec_ones, inc);
                        2'd1: set_sec_tens <= step_tens(set_sec_tens, inc);
                        2'd2: set_min_ones <= step_ones(set_min_ones, inc);
                        default: set_min_tens <= step_tens(set_min_tens, inc);
                    endcase
                end
            end
        end
    end

    // Blink phase restarts dark on entering EDIT and on every selection move
    always_ff @(posedge clk) begin
        if (reset || state == RUN || go_edit || mv_l || mv_r) begin
            blink_cnt <= BL_LOAD;
            blink_ph  <= 1'b0;
        end else if (blink_cnt == '0) begin
            blink_cnt <= BL_LOAD;
            blink_ph  <= ~blink_ph;
        end else begin
            blink_cnt <= blink_cnt - BW'(1);
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with short debounce/blink/repeat periods.
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_c, btn_l, btn_r, btn_u, btn_d;
    logic [3:0] cur_sec_ones, cur_min_ones;
    logic [2:0] cur_sec_tens, cur_min_tens;
    logic       timer_en, load;
    logic [3:0] set_sec_ones, set_min_ones;
    logic [2:0] set_sec_tens, set_min_tens;
    logic [1:0] digit_sel;
    logic [3:0] blink_mask;

    localparam logic [4:0] PC = 5'b00001, PL = 5'b00010, PR = 5'b00100, PU = 5'b01000, PD = 5'b10000;

    int n_checks = 0;
    int n_pass = 0;
    int load_count = 0;
    bit load_long = 0;
    logic load_prev = 1'b0;
    logic [13:0] ld_val = '0;
    int lc0;

    clock_set_ctrl #(.DEBOUNCE_CYCLES(4), .BLINK_CYCLES(8), .REPEAT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .btn_c(btn_c), .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d),
        .cur_sec_ones(cur_sec_ones), .cur_sec_tens(cur_sec_tens),
        .cur_min_ones(cur_min_ones), .cur_min_tens(cur_min_tens),
        .timer_en(timer_en), .load(load),
        .set_sec_ones(set_sec_ones), .set_sec_tens(set_sec_tens),
        .set_min_ones(set_min_ones), .set_min_tens(set_min_tens),
        .digit_sel(digit_sel), .blink_mask(blink_mask)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (load) begin
            load_count++;
            ld_val = {set_min_tens, set_min_ones, set_sec_tens, set_sec_ones};
            if (load_prev) load_long = 1;
        end
        load_prev = load;
    end

    function automatic logic [13:0] packed_set();
        return {set_min_tens, set_min_ones, set_sec_tens, set_sec_ones};
    endfunction

    function automatic logic [13:0] mk(input int mt, input int mo, input int st, input int so);
        return {3'(mt), 4'(mo), 3'(st), 4'(so)};
    endfunction

    task automatic drive(input logic [4:0] b);
        {btn_d, btn_u, btn_r, btn_l, btn_c} = b;
    endtask

    task automatic press(input logic [4:0] b);
        @(negedge clk);
        drive(b);
        repeat (15) @(negedge clk);
        drive(5'b0);
        repeat (15) @(negedge clk);
    endtask

    task automatic set_cur(input int mt, input int mo, input int st, input int so);
        cur_min_tens = 3'(mt);
        cur_min_ones = 4'(mo);
        cur_sec_tens = 3'(st);
        cur_sec_ones = 4'(so);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (timer_en !== 1'b1) $display("FAIL reset_timer_en got %b want 1", timer_en); else n_pass++;
        n_checks++; if (load !== 1'b0) $display("FAIL reset_load got %b want 0", load); else n_pass++;
        n_checks++; if (packed_set() !== 14'h0) $display("FAIL reset_set got %h want 0", packed_set()); else n_pass++;
        n_checks++; if (digit_sel !== 2'd0) $display("FAIL reset_digit_sel got %0d want 0", digit_sel); else n_pass++;
        n_checks++; if (blink_mask !== 4'b0) $display("FAIL reset_blink got %b want 0000", blink_mask); else n_pass++;
    endtask

    task automatic test_bounce_run();
        logic [3:0] pat;
        pat = 4'b1010;
        set_cur(1, 2, 3, 4);
        lc0 = load_count;
        for (int i = 3; i >= 0; i--) begin
            @(negedge clk);
            drive(pat[i] ? PU : 5'b0);
        end
        @(negedge clk);
        drive(PU);
        repeat (20) @(negedge clk);
        drive(5'b0);
        repeat (15) @(negedge clk);
        n_checks++; if (packed_set() !== 14'h0) $display("FAIL bounce_set got %h want 0", packed_set()); else n_pass++;
        n_checks++; if (timer_en !== 1'b1) $display("FAIL bounce_timer_en got %b want 1", timer_en); else n_pass++;
        n_checks++; if (load_count !== lc0) $display("FAIL bounce_load got %0d want %0d", load_count, lc0); else n_pass++;
    endtask

    task automatic test_edit_inc();
        press(PC);
        n_checks++; if (timer_en !== 1'b0) $display("FAIL edit_timer_en got %b want 0", timer_en); else n_pass++;
        n_checks++; if (packed_set() !== mk(1, 2, 3, 4)) $display("FAIL edit_snapshot got %h want %h", packed_set(), mk(1, 2, 3, 4)); else n_pass++;
        n_checks++; if (digit_sel !== 2'd0) $display("FAIL edit_digit_sel got %0d want 0", digit_sel); else n_pass++;
        repeat (6) press(PU);
        n_checks++; if (packed_set() !== mk(1, 2, 3, 0)) $display("FAIL inc_wrap got %h want %h", packed_set(), mk(1, 2, 3, 0)); else n_pass++;
        @(negedge clk);
        drive(PU);
        repeat (2) @(negedge clk);
        drive(5'b0);
        repeat (15) @(negedge clk);
        n_checks++; if (packed_set() !== mk(1, 2, 3, 0)) $display("FAIL glitch_ignored got %h want %h", packed_set(), mk(1, 2, 3, 0)); else n_pass++;
        lc0 = load_count;
        press(PC);
        n_checks++; if (load_count !== lc0 + 1) $display("FAIL exit_load_count got %0d want %0d", load_count, lc0 + 1); else n_pass++;
        n_checks++; if (load_long !== 1'b0) $display("FAIL exit_load_width got %b want 0", load_long); else n_pass++;
        n_checks++; if (ld_val !== mk(1, 2, 3, 0)) $display("FAIL exit_load_value got %h want %h", ld_val, mk(1, 2, 3, 0)); else n_pass++;
        n_checks++; if (timer_en !== 1'b1) $display("FAIL exit_timer_en got %b want 1", timer_en); else n_pass++;
    endtask

    task automatic test_digit_select();
        set_cur(0, 2, 3, 4);
        press(PC);
        press(PR);
        n_checks++; if (digit_sel !== 2'd3) $display("FAIL sel_r_wrap got %0d want 3", digit_sel); else n_pass++;
        press(PD);
        n_checks++; if (packed_set() !== mk(5, 2, 3, 4)) $display("FAIL dec_tens_wrap got %h want %h", packed_set(), mk(5, 2, 3, 4)); else n_pass++;
        press(PL);
        n_checks++; if (digit_sel !== 2'd0) $display("FAIL sel_l_wrap got %0d want 0", digit_sel); else n_pass++;
    endtask

    task automatic test_simultaneous();
        press(PL | PR);
        n_checks++; if (digit_sel !== 2'd0) $display("FAIL lr_cancel got %0d want 0", digit_sel); else n_pass++;
        press(PL | PU);
        n_checks++; if (digit_sel !== 2'd1) $display("FAIL lu_sel got %0d want 1", digit_sel); else n_pass++;
        n_checks++; if (packed_set() !== mk(5, 2, 3, 4)) $display("FAIL lu_value got %h want %h", packed_set(), mk(5, 2, 3, 4)); else n_pass++;
        press(PU | PD);
        n_checks++; if (packed_set() !== mk(5, 2, 3, 4)) $display("FAIL ud_cancel got %h want %h", packed_set(), mk(5, 2, 3, 4)); else n_pass++;
        lc0 = load_count;
        press(PC | PU);
        n_checks++; if (timer_en !== 1'b1) $display("FAIL cu_run got %b want 1", timer_en); else n_pass++;
        n_checks++; if (load_count !== lc0 + 1) $display("FAIL cu_load got %0d want %0d", load_count, lc0 + 1); else n_pass++;
        n_checks++; if (packed_set() !== mk(5, 2, 3, 4)) $display("FAIL cu_value got %h want %h", packed_set(), mk(5, 2, 3, 4)); else n_pass++;
    endtask

    task automatic test_saturation();
        set_cur(7, 11, 6, 12);
        press(PC);
        n_checks++; if (packed_set() !== mk(5, 9, 5, 9)) $display("FAIL saturate got %h want %h", packed_set(), mk(5, 9, 5, 9)); else n_pass++;
        press(PC);
    endtask

    task automatic test_blink_reset();
        int wait_n;
        logic [3:0] exp_mask;
        set_cur(0, 0, 0, 0);
        @(negedge clk);
        drive(PC);
        wait_n = 0;
        while (timer_en !== 1'b0 && wait_n < 40) begin
            @(negedge clk);
            wait_n++;
        end
        drive(5'b0);
        n_checks++; if (timer_en !== 1'b0) $display("FAIL blink_enter_timeout got %b want 0", timer_en); else n_pass++;
        for (int k = 0; k < 24; k++) begin
            exp_mask = ((k / 8) % 2 == 1) ? 4'b0001 : 4'b0000;
            n_checks++; if (blink_mask !== exp_mask) $display("FAIL blink_k%0d got %b want %b", k, blink_mask, exp_mask); else n_pass++;
            @(negedge clk);
        end
        lc0 = load_count;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (timer_en !== 1'b1) $display("FAIL rst_edit_timer_en got %b want 1", timer_en); else n_pass++;
        n_checks++; if (blink_mask !== 4'b0) $display("FAIL rst_edit_blink got %b want 0000", blink_mask); else n_pass++;
        n_checks++; if (load_count !== lc0) $display("FAIL rst_edit_load got %0d want %0d", load_count, lc0); else n_pass++;
    endtask

    task automatic test_repeat();
        logic [3:0] exp_so;
`ifdef AUTO_REPEAT_EN
        exp_so = 4'd0;
`else
        exp_so = 4'd8;
`endif
        set_cur(0, 0, 0, 7);
        press(PC);
        @(negedge clk);
        drive(PU);
        repeat (42) @(negedge clk);
        drive(5'b0);
        repeat (20) @(negedge clk);
        n_checks++; if (set_sec_ones !== exp_so) $display("FAIL hold_u got %0d want %0d", set_sec_ones, exp_so); else n_pass++;
        press(PC);
    endtask

    initial begin
        reset = 1'b1;
        drive(5'b0);
        set_cur(0, 0, 0, 0);
        test_reset();
        test_bounce_run();
        test_edit_inc();
        test_digit_select();
        test_simultaneous();
        test_saturation();
        test_blink_reset();
        test_repeat();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
